id_ex_stage: RTL and testbench

- Pipeline register between decode and execute.
- Captures the three register-file read ports (rs1, rs2, rd data) plus decode control.
- Applies a same-cycle write-back bypass, because the register file writes on the clock edge and its combinational read returns the old value in the write cycle.
- Detects load-use hazards, inserts an EX bubble, and requests an IF/ID freeze. Keeps a saturating bubble counter for performance monitoring.

---
 rtl/id_ex_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle write-back bypass, load-use bubble
// insertion and a saturating count of inserted bubbles.
module id_ex_stage #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_rd_used,
    input  logic [31:0]       id_rs1_data,
    input  logic [31:0]       id_rs2_data,
    input  logic [31:0]       id_rd_data,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [31:0]       ex_rs1_data,
    output logic [31:0]       ex_rs2_data,
    output logic [31:0]       ex_rd_data,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [31:0]       rs1_data;
        logic [31:0]       rs2_data;
        logic [31:0]       rd_data;
        logic [CTRL_W-1:0] ctrl;
        logic              reg_write;
        logic              mem_read;
    } ex_t;

    ex_t              r_ex;
    ex_t              w_load;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_hazard;
    logic             w_wb_hit_rs1;
    logic             w_wb_hit_rs2;
    logic             w_wb_hit_rd;

    // The register file returns the pre-write value during its write cycle.
    assign w_wb_hit_rs1 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1);
    assign w_wb_hit_rs2 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2);
    assign w_wb_hit_rd  = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rd);

    assign w_hazard = r_ex.valid && r_ex.mem_read && (r_ex.rd != 5'd0) && id_valid &&
                      ((r_ex.rd == id_rs1) || (r_ex.rd == id_rs2) ||
                       (id_rd_used && (r_ex.rd == id_rd)));

    always_comb begin
        w_load           = '0;
        w_load.valid     = id_valid;
        w_load.pc        = id_pc;
        w_load.imm       = id_imm;
        w_load.rs1       = id_rs1;
        w_load.rs2       = id_rs2;
        w_load.rd        = id_rd;
        w_load.rs1_data  = w_wb_hit_rs1 ? wb_data : id_rs1_data;
        w_load.rs2_data  = w_wb_hit_rs2 ? wb_data : id_rs2_data;
        w_load.rd_data   = w_wb_hit_rd  ? wb_data : id_rd_data;
        w_load.ctrl      = id_valid ? id_ctrl : '0;
        w_load.reg_write = id_valid && id_reg_write;
        w_load.mem_read  = id_valid && id_mem_read;
    end

    // Flush beats stall; a hazard only bubbles when the pipe is not frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex <= '0;
        end else if (flush || (!stall && w_hazard)) begin
            r_ex <= '0;
        end else if (!stall) begin
            r_ex <= w_load;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= '0;
        end else if (!flush && !stall && w_hazard && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign ex_valid     = r_ex.valid;
    assign ex_pc        = r_ex.pc;
    assign ex_imm       = r_ex.imm;
    assign ex_rs1       = r_ex.rs1;
    assign ex_rs2       = r_ex.rs2;
    assign ex_rd        = r_ex.rd;
    assign ex_rs1_data  = r_ex.rs1_data;
    assign ex_rs2_data  = r_ex.rs2_data;
    assign ex_rd_data   = r_ex.rd_data;
    assign ex_ctrl      = r_ex.ctrl;
    assign ex_reg_write = r_ex.reg_write;
    assign ex_mem_read  = r_ex.mem_read;
    assign hazard_stall = w_hazard;
    assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed cases pinned to literals, then random traffic
// compared every cycle against a behavioural model; a CNT_W=2 copy covers saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        id_valid, id_rd_used, id_reg_write, id_mem_read;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_rd_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [15:0] id_ctrl;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        ex_valid, ex_reg_write, ex_mem_read, hazard_stall;
    logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rd_data;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [15:0] ex_ctrl;
    logic [15:0] bubble_cnt;

    logic        ex_valid2, ex_reg_write2, ex_mem_read2, hazard_stall2;
    logic [31:0] ex_pc2, ex_imm2, ex_rs1_data2, ex_rs2_data2, ex_rd_data2;
    logic [4:0]  ex_rs12, ex_rs22, ex_rd2;
    logic [15:0] ex_ctrl2;
    logic [1:0]  bubble_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.CTRL_W(16), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd_used(id_rd_used), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rd_data(id_rd_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rd_data(ex_rd_data), .ex_ctrl(ex_ctrl), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.CTRL_W(16), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd_used(id_rd_used), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rd_data(id_rd_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid2), .ex_pc(ex_pc2), .ex_imm(ex_imm2), .ex_rs1(ex_rs12), .ex_rs2(ex_rs22),
        .ex_rd(ex_rd2), .ex_rs1_data(ex_rs1_data2), .ex_rs2_data(ex_rs2_data2),
        .ex_rd_data(ex_rd_data2), .ex_ctrl(ex_ctrl2), .ex_reg_write(ex_reg_write2),
        .ex_mem_read(ex_mem_read2), .hazard_stall(hazard_stall2), .bubble_cnt(bubble_cnt2)
    );

    // Behavioural model: what instruction EX should be holding, plus a raw
    // (unbounded) count of bubbles that is saturated only when compared.
    logic        m_valid, m_rw, m_mr;
    logic [31:0] m_pc, m_imm, m_d1, m_d2, m_d3;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [15:0] m_ctrl;
    int unsigned m_bub;

    function automatic logic [31:0] reg_value(input logic [4:0] idx, input logic [31:0] rf);
        if (wb_reg_write && idx != 5'd0 && idx == wb_rd) return wb_data;
        return rf;
    endfunction

    function automatic bit model_hazard();
        if (!(m_valid && m_mr && m_rd != 5'd0 && id_valid)) return 1'b0;
        return (m_rd == id_rs1) || (m_rd == id_rs2) || (id_rd_used && m_rd == id_rd);
    endfunction

    function automatic int unsigned sat(input int unsigned n, input int unsigned w);
        int unsigned mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_bubble();
        {m_valid, m_rw, m_mr} = '0;
        {m_pc, m_imm, m_d1, m_d2, m_d3} = '0;
        {m_rs1, m_rs2, m_rd} = '0;
        m_ctrl = '0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_bubble();
            m_bub = 0;
        end else if (flush) begin
            model_bubble();
        end else if (stall) begin
            // EX keeps the instruction it has
        end else if (model_hazard()) begin
            model_bubble();
            m_bub++;
        end else begin
            m_valid = id_valid;
            m_rw    = id_valid & id_reg_write;
            m_mr    = id_valid & id_mem_read;
            m_ctrl  = id_valid ? id_ctrl : 16'h0;
            m_pc    = id_pc;
            m_imm   = id_imm;
            m_rs1   = id_rs1;
            m_rs2   = id_rs2;
            m_rd    = id_rd;
            m_d1    = reg_value(id_rs1, id_rs1_data);
            m_d2    = reg_value(id_rs2, id_rs2_data);
            m_d3    = reg_value(id_rd, id_rd_data);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("ex_valid", 64'(ex_valid), 64'(m_valid));
        check("ex_pc", 64'(ex_pc), 64'(m_pc));
        check("ex_imm", 64'(ex_imm), 64'(m_imm));
        check("ex_idx", 64'({ex_rs1, ex_rs2, ex_rd}), 64'({m_rs1, m_rs2, m_rd}));
        check("ex_rs1_data", 64'(ex_rs1_data), 64'(m_d1));
        check("ex_rs2_data", 64'(ex_rs2_data), 64'(m_d2));
        check("ex_rd_data", 64'(ex_rd_data), 64'(m_d3));
        check("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
        check("ex_rw_mr", 64'({ex_reg_write, ex_mem_read}), 64'({m_rw, m_mr}));
        check("hazard_stall", 64'(hazard_stall), 64'(model_hazard()));
        check("bubble_cnt", 64'(bubble_cnt), 64'(sat(m_bub, 16)));
        check("bubble_cnt_w2", 64'(bubble_cnt2), 64'(sat(m_bub, 2)));
        check("ex_valid_w2", 64'(ex_valid2), 64'(m_valid));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        {stall, flush, id_valid, id_rd_used, id_reg_write, id_mem_read, wb_reg_write} = '0;
        {id_pc, id_rs1_data, id_rs2_data, id_rd_data, id_imm, wb_data} = '0;
        {id_rs1, id_rs2, id_rd, wb_rd} = '0;
        id_ctrl = '0;
    endtask

    task automatic issue_load(input logic [4:0] rd);
        idle_inputs();
        id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = rd;
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_pc = 32'h40; id_ctrl = 16'h00A5;
        tick();
    endtask

    // Load to x7 followed by a consumer of x7: exactly one bubble.
    task automatic make_hazard();
        issue_load(5'd7);
        idle_inputs();
        id_valid = 1'b1; id_rs1 = 5'd7;
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_valid", 64'(ex_valid), 64'd0);
        check("reset_cnt", 64'(bubble_cnt), 64'd0);

        // write-back bypass
        id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd5;
        id_rs1_data = 32'h11111111; id_rs2_data = 32'h11111111;
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        check("bypass_rs1", 64'(ex_rs1_data), 64'hDEADBEEF);
        check("bypass_rs2", 64'(ex_rs2_data), 64'hDEADBEEF);

        // x0 is never bypassed
        wb_rd = 5'd0; wb_data = 32'hFFFFFFFF; id_rs1 = 5'd0; id_rs1_data = 32'h0;
        tick();
        check("x0_guard", 64'(ex_rs1_data), 64'd0);

        // load-use on rs2
        issue_load(5'd7);
        check("load_in_ex", 64'({ex_valid, ex_mem_read}), 64'b11);
        idle_inputs();
        id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd7; id_rd = 5'd3;
        #1 check("lu_hazard", 64'(hazard_stall), 64'd1);
        tick();
        check("lu_bubble", 64'(ex_valid), 64'd0);
        check("lu_cnt", 64'(bubble_cnt), 64'd1);
        check("lu_no_hazard", 64'(hazard_stall), 64'd0);
        tick();
        check("lu_reissue", 64'({ex_valid, ex_rs2}), 64'({1'b1, 5'd7}));

        // store-data hazard through rd
        issue_load(5'd9);
        idle_inputs();
        id_valid = 1'b1; id_rd = 5'd9; id_rd_used = 1'b1;
        #1 check("st_hazard", 64'(hazard_stall), 64'd1);
        tick();
        check("st_cnt", 64'({ex_valid, bubble_cnt}), 64'({1'b0, 16'd2}));
        issue_load(5'd9);
        idle_inputs();
        id_valid = 1'b1; id_rd = 5'd9; id_rd_used = 1'b0;
        #1 check("st_unused", 64'(hazard_stall), 64'd0);
        tick();
        check("st_no_bubble", 64'({ex_valid, bubble_cnt}), 64'({1'b1, 16'd2}));

        // stall holds, flush beats stall
        idle_inputs();
        id_valid = 1'b1; id_reg_write = 1'b1; id_pc = 32'h100;
        tick();
        stall = 1'b1; id_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", 64'({ex_valid, ex_pc}), 64'({1'b1, 32'h100}));
        end
        flush = 1'b1;
        tick();
        check("flush_over_stall", 64'({ex_valid, ex_reg_write}), 64'd0);

        // stall and hazard together: hold, no bubble, no count
        issue_load(5'd7);
        idle_inputs();
        id_valid = 1'b1; id_rs1 = 5'd7; stall = 1'b1;
        tick();
        check("stall_hazard", 64'({ex_valid, ex_mem_read, bubble_cnt}), 64'({2'b11, 16'd2}));
        stall = 1'b0;
        tick();
        check("stall_hazard_rel", 64'(bubble_cnt), 64'd3);

        make_hazard();
        make_hazard();
        check("cnt5", 64'(bubble_cnt), 64'd5);
        check("cnt_w2_sat", 64'(bubble_cnt2), 64'd3);
        idle_inputs();
        id_valid = 1'b1; id_pc = 32'h300;
        tick();

        // asynchronous reset between edges
        #2 reset = 1'b1;
        #1 check("async_rst", 64'({ex_valid, ex_pc, bubble_cnt}), 64'd0);
        check("async_rst_w2", 64'(bubble_cnt2), 64'd0);
        reset = 1'b0;
        tick();

        // randomized traffic; small index range keeps hazards and bypass frequent
        for (int i = 0; i < 3000; i++) begin
            stall        = ($urandom_range(0, 9) == 0);
            flush        = ($urandom_range(0, 19) == 0);
            id_valid     = ($urandom_range(0, 4) != 0);
            id_mem_read  = ($urandom_range(0, 2) == 0);
            id_reg_write = $urandom_range(0, 1);
            id_rd_used   = $urandom_range(0, 1);
            id_rs1       = 5'($urandom_range(0, 7));
            id_rs2       = 5'($urandom_range(0, 7));
            id_rd        = 5'($urandom_range(0, 7));
            id_pc        = $urandom;
            id_imm       = $urandom;
            id_ctrl      = 16'($urandom);
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            id_rd_data   = $urandom;
            wb_reg_write = $urandom_range(0, 1);
            wb_rd        = 5'($urandom_range(0, 7));
            wb_data      = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
